// File: rtl/latch_wr_sched.sv
// Round-robin write scheduler for a shared D-latch bank.
// Each write runs SETUP -> OPEN -> HOLD so lat_d is stable while lat_en is open.
module latch_wr_sched #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int OPEN_CYC = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] wdata,
    input  logic              clr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              clr_ack,
    output logic [W-1:0]      lat_d,
    output logic              lat_en,
    output logic              lat_rstn,
    output logic              busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = PW + 1;
    localparam int CW = $clog2(OPEN_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLR, SETUP, OPEN, HOLD} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt, win, win_nxt, sel;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              found, grant;
    logic [NREQ-1:0]   gnt_nxt, ack_nxt;
    logic [W-1:0]      lat_d_nxt;
    logic              clr_ack_nxt, lat_en_nxt, busy_nxt;

    // Rotating priority search: first requester at or above ptr, wrapping.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= IW'(NREQ))
                idx = idx - IW'(NREQ);
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            ack     <= '0;
            clr_ack <= 1'b0;
            lat_d   <= '0;
            lat_en  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            ack     <= ack_nxt;
            clr_ack <= clr_ack_nxt;
            lat_d   <= lat_d_nxt;
            lat_en  <= lat_en_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr)
                    state_nxt = CLR;
                else if (found) begin
                    state_nxt = SETUP;
                    win_nxt   = sel;
                end
            end
            CLR:   state_nxt = IDLE;
            SETUP: begin
                state_nxt = OPEN;
                cnt_nxt   = CW'(OPEN_CYC - 1);
            end
            OPEN: begin
                if (cnt == '0)
                    state_nxt = HOLD;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            HOLD: begin
                state_nxt = IDLE;
                ptr_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are computed from the state being entered.
    always_comb begin
        grant       = (state == IDLE) && (state_nxt == SETUP);
        gnt_nxt     = gnt;
        lat_d_nxt   = lat_d;
        if (grant) begin
            gnt_nxt   = NREQ'(1) << sel;
            lat_d_nxt = wdata[sel*W +: W];
        end else if (state == HOLD) begin
            gnt_nxt   = '0;
        end
        ack_nxt     = (state_nxt == HOLD) ? gnt : '0;
        lat_en_nxt  = (state_nxt == OPEN);
        clr_ack_nxt = (state_nxt == CLR);
        busy_nxt    = (state_nxt != IDLE);
    end

    // Combinational so the latch clears together with an async reset.
    assign lat_rstn = rstn & (state != CLR);

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: directed scenarios plus random traffic, each cycle
// compared to a transaction-timeline model (age of the current write since grant).
module tb_latch_wr_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int OC   = 2;
    localparam int VW   = 2*NREQ + W + 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] wdata = '0;
    logic              clr = 1'b0;
    logic [NREQ-1:0]   gnt, ack;
    logic              clr_ack, lat_en, lat_rstn, busy;
    logic [W-1:0]      lat_d;
    logic [VW-1:0]     act;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latch_wr_sched #(.NREQ(NREQ), .W(W), .OPEN_CYC(OC)) dut (
        .clk(clk), .rstn(rstn), .req(req), .wdata(wdata), .clr(clr),
        .gnt(gnt), .ack(ack), .clr_ack(clr_ack), .lat_d(lat_d),
        .lat_en(lat_en), .lat_rstn(lat_rstn), .busy(busy)
    );

    assign act = {gnt, ack, clr_ack, lat_d, lat_en, lat_rstn, busy};

    // Model: a write is "age" edges old; grant at age 0, enable for ages
    // 1..OC, ack at OC+1, free again at OC+2. A clear occupies one cycle.
    logic       m_tr, m_clr;
    int         m_age, m_win, m_ptr;
    logic [W-1:0] m_d;

    function automatic void model_reset();
        m_tr = 1'b0; m_clr = 1'b0; m_age = 0; m_win = 0; m_ptr = 0; m_d = '0;
    endfunction

    function automatic void model_step();
        bit got;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (m_tr) begin
            m_age++;
            if (m_age == OC + 2) begin
                m_tr  = 1'b0;
                m_ptr = (m_win + 1) % NREQ;
            end
        end else if (m_clr) begin
            m_clr = 1'b0;
        end else if (clr) begin
            m_clr = 1'b1;
        end else if (req != '0) begin
            got = 0;
            for (int k = 0; k < NREQ; k++)
                if (!got && req[(m_ptr + k) % NREQ]) begin
                    got   = 1;
                    m_win = (m_ptr + k) % NREQ;
                end
            m_tr  = 1'b1;
            m_age = 0;
            m_d   = wdata[m_win*W +: W];
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NREQ-1:0] g, a;
        logic en;
        g  = m_tr ? (NREQ'(1) << m_win) : '0;
        a  = (m_tr && m_age == OC + 1) ? g : '0;
        en = m_tr && m_age >= 1 && m_age <= OC;
        return {g, a, m_clr, m_d, en, rstn & ~m_clr, m_tr | m_clr};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0; req = '0; clr = 1'b0;
        model_reset();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = '1; wdata = {$urandom, $urandom};
        model_reset();
        repeat (3) tick();
        checks++; if (gnt !== '0)     begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        checks++; if (lat_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", lat_en); end
        checks++; if (lat_rstn !== 1'b0) begin errors++; $display("FAIL reset_lat_rstn: got %b want 0", lat_rstn); end
        checks++; if (lat_d !== 8'h00) begin errors++; $display("FAIL reset_lat_d: got %h want 00", lat_d); end
        req = '0; rstn = 1'b1;
        tick();
        checks++; if (lat_rstn !== 1'b1) begin errors++; $display("FAIL release_lat_rstn: got %b want 1", lat_rstn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        apply_reset();
        wdata = {$urandom, $urandom};
        wdata[7:0] = 8'hA5;
        req = 4'b0001;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (j == 0) req = '0;
            checks++; if (act !== exp_vec()) begin errors++; $display("FAIL single_model j=%0d: dut=%h model=%h", j, act, exp_vec()); end
            if (j == 0) begin
                checks++; if (gnt !== 4'b0001 || lat_d !== 8'hA5) begin errors++; $display("FAIL single_grant: gnt=%b d=%h want 0001/a5", gnt, lat_d); end
            end
            checks++; if (lat_en !== (j == 1 || j == 2)) begin errors++; $display("FAIL single_en j=%0d: got %b", j, lat_en); end
            checks++; if (ack !== ((j == 3) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_ack j=%0d: got %b", j, ack); end
            if (j == 4) begin
                checks++; if (gnt !== '0) begin errors++; $display("FAIL single_release: gnt=%b want 0", gnt); end
            end
        end
    endtask

    task automatic test_round_robin();
        int order[$], rise[$];
        logic [NREQ-1:0] prev;
        apply_reset();
        wdata = {$urandom, $urandom};
        req = '1;
        prev = '0;
        for (int j = 0; j < 21; j++) begin
            tick();
            checks++; if (act !== exp_vec()) begin errors++; $display("FAIL rr_model j=%0d: dut=%h model=%h", j, act, exp_vec()); end
            if (gnt != '0 && prev == '0) begin
                order.push_back($clog2(gnt));
                rise.push_back(j);
                checks++; if (lat_d !== wdata[$clog2(gnt)*W +: W]) begin errors++; $display("FAIL rr_data j=%0d: got %h want %h", j, lat_d, wdata[$clog2(gnt)*W +: W]); end
            end
            prev = gnt;
        end
        req = '0;
        checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_count: got %0d want 5", order.size()); end
        for (int k = 0; k < order.size() && k < 5; k++) begin
            checks++; if (order[k] != k % NREQ) begin errors++; $display("FAIL rr_order k=%0d: got %0d want %0d", k, order[k], k % NREQ); end
            if (k > 0) begin
                checks++; if (rise[k] - rise[k-1] != 3 + OC) begin errors++; $display("FAIL rr_spacing k=%0d: got %0d want %0d", k, rise[k] - rise[k-1], 3 + OC); end
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_clear();
        int seen;
        apply_reset();
        wdata = {$urandom, $urandom};
        clr = 1'b1; req = 4'b0010;
        tick();
        clr = 1'b0;
        checks++; if (clr_ack !== 1'b1 || lat_rstn !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL clr_first: ack=%b rstn=%b gnt=%b want 1/0/0", clr_ack, lat_rstn, gnt); end
        tick();
        checks++; if (clr_ack !== 1'b0 || lat_rstn !== 1'b1 || gnt !== '0) begin errors++; $display("FAIL clr_idle: ack=%b rstn=%b gnt=%b want 0/1/0", clr_ack, lat_rstn, gnt); end
        tick();
        req = '0;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL clr_then_grant: gnt=%b want 0010", gnt); end
        seen = -1;
        for (int j = 1; j < 8; j++) begin
            tick();
            if (j == 1) clr = 1'b1;
            checks++; if (act !== exp_vec()) begin errors++; $display("FAIL clr_model j=%0d: dut=%h model=%h", j, act, exp_vec()); end
            if (clr_ack && seen < 0) begin
                seen = j;
                clr = 1'b0;
            end
        end
        checks++; if (seen != OC + 3) begin errors++; $display("FAIL clr_pending: served at %0d want %0d", seen, OC + 3); end
    endtask

    task automatic test_robust();
        logic [W-1:0] d0;
        d0 = W'($urandom);
        wdata = {$urandom, $urandom};
        wdata[2*W +: W] = d0;
        req = 4'b0100;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (j == 1) begin
                req = '0;
                wdata[2*W +: W] = ~d0;
            end
            checks++; if (act !== exp_vec()) begin errors++; $display("FAIL robust_model j=%0d: dut=%h model=%h", j, act, exp_vec()); end
            if (j <= 4) begin
                checks++; if (lat_d !== d0) begin errors++; $display("FAIL robust_data j=%0d: got %h want %h", j, lat_d, d0); end
            end
            if (j == 3) begin
                checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL robust_ack: got %b want 0100", ack); end
            end
        end
        req = 4'b0100;
        tick();
        tick();
        req = '0;
        checks++; if (lat_en !== 1'b1) begin errors++; $display("FAIL robust_open: lat_en=%b want 1", lat_en); end
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        checks++; if (lat_en !== 1'b0 || gnt !== '0 || lat_rstn !== 1'b0) begin errors++; $display("FAIL async_reset: en=%b gnt=%b rstn=%b want 0/0/0", lat_en, gnt, lat_rstn); end
        req = 4'b1010;
        repeat (2) begin
            tick();
            checks++; if (ack !== '0) begin errors++; $display("FAIL reset_no_ack: got %b want 0", ack); end
        end
        rstn = 1'b1;
        tick();
        req = '0;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL reset_ptr: gnt=%b want 0010", gnt); end
        repeat (5) tick();
    endtask

    task automatic test_random();
        for (int j = 0; j < 300; j++) begin
            req   = NREQ'($urandom) & NREQ'($urandom);
            clr   = ($urandom_range(0, 15) == 0);
            wdata = {$urandom, $urandom};
            tick();
            checks++; if (act !== exp_vec()) begin errors++; $display("FAIL random_model j=%0d: dut=%h model=%h", j, act, exp_vec()); end
        end
        req = '0; clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_clear();
        test_robust();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
